// File: rtl/ecpri_tx.sv
// eCPRI RMA response builder: header template copy, 16-byte eCPRI header, optional payload,
// then valid/ack hand-off to the MAC. Define ECPRI_TX_LEN_FIXUP_EN to patch IP/UDP lengths.
module ecpri_tx #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 16,
  parameter int NET_HDR_LEN   = 42,
  parameter int ECPRI_HDR_LEN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  send_read_resp,
  input  logic                  send_write_resp,
  input  logic [7:0]            resp_payload_len,
  input  logic [7:0]            resp_id,
  input  logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH-1:0] addr_0,
  input  logic [DATA_WIDTH-1:0] data_0,
  output logic                  oe_0,
  output logic [ADDR_WIDTH-1:0] addr_1,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic                  we_1,
  output logic [ADDR_WIDTH-1:0] addr_2,
  input  logic [DATA_WIDTH-1:0] data_2,
  output logic                  oe_2,
  output logic                  tx_pkt_valid,
  output logic [ADDR_WIDTH-1:0] tx_pkt_len,
  input  logic                  tx_ack,
  output logic                  busy
);

  localparam int FRAME_BASE = NET_HDR_LEN + ECPRI_HDR_LEN;
`ifdef ECPRI_TX_LEN_FIXUP_EN
  localparam bit LEN_FIXUP = 1'b1;
`else
  localparam bit LEN_FIXUP = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, COPY_HDR, WR_ECPRI, COPY_PAYLOAD, DONE} state_e;
  typedef enum logic [1:0] {SRC_REG, SRC_TMPL, SRC_PAY} src_e;

  state_e                state;
  src_e                  src;
  logic [7:0]            cnt;
  logic [DATA_WIDTH-1:0] byte_q;

  logic                  rd_pend, wr_pend;
  logic [7:0]            rd_len, rd_id, wr_id;
  logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;

  logic                  cur_read;
  logic [7:0]            cur_len, cur_id;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // eCPRI common + RMA response header, byte idx of 16
  function automatic logic [7:0] ecpri_byte(input logic [3:0] idx);
    logic [15:0] size;
    logic [15:0] a16;
    size = 16'd12 + {8'd0, cur_len};
    a16  = 16'(cur_addr);
    case (idx)
      4'd0:    ecpri_byte = 8'h10;
      4'd1:    ecpri_byte = 8'h04;
      4'd2:    ecpri_byte = size[15:8];
      4'd3:    ecpri_byte = size[7:0];
      4'd4:    ecpri_byte = cur_id;
      4'd5:    ecpri_byte = cur_read ? 8'h01 : 8'h11;
      4'd12:   ecpri_byte = a16[15:8];
      4'd13:   ecpri_byte = a16[7:0];
      4'd15:   ecpri_byte = cur_len;
      default: ecpri_byte = 8'h00;
    endcase
  endfunction

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      src          <= SRC_REG;
      cnt          <= '0;
      byte_q       <= '0;
      rd_pend      <= 1'b0;
      wr_pend      <= 1'b0;
      rd_len       <= '0;
      rd_id        <= '0;
      wr_id        <= '0;
      rd_addr      <= '0;
      wr_addr      <= '0;
      cur_read     <= 1'b0;
      cur_len      <= '0;
      cur_id       <= '0;
      cur_addr     <= '0;
      addr_0       <= '0;
      oe_0         <= 1'b0;
      addr_1       <= '0;
      we_1         <= 1'b0;
      addr_2       <= '0;
      oe_2         <= 1'b0;
      tx_pkt_valid <= 1'b0;
      tx_pkt_len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_pend || wr_pend) begin
            state  <= COPY_HDR;
            cnt    <= '0;
            addr_0 <= '0;
            oe_0   <= 1'b1;
          end
          if (rd_pend) begin
            rd_pend  <= 1'b0;
            cur_read <= 1'b1;
            cur_len  <= rd_len;
            cur_id   <= rd_id;
            cur_addr <= rd_addr;
          end else if (wr_pend) begin
            wr_pend  <= 1'b0;
            cur_read <= 1'b0;
            cur_len  <= '0;
            cur_id   <= wr_id;
            cur_addr <= wr_addr;
          end
        end
        COPY_HDR: begin
          cnt <= cnt + 8'd1;
          if (cnt < 8'(NET_HDR_LEN - 1)) addr_0 <= addr_0 + 1'b1;
          else                           oe_0   <= 1'b0;
          if (cnt < 8'(NET_HDR_LEN)) begin
            // template byte for offset cnt is on data_0 during the next cycle
            we_1   <= 1'b1;
            addr_1 <= ADDR_WIDTH'(cnt);
            src    <= SRC_TMPL;
          end else begin
            we_1   <= 1'b1;
            addr_1 <= ADDR_WIDTH'(NET_HDR_LEN);
            src    <= SRC_REG;
            byte_q <= ecpri_byte(4'd0);
            cnt    <= '0;
            state  <= WR_ECPRI;
          end
        end
        WR_ECPRI: begin
          if (cnt < 8'(ECPRI_HDR_LEN - 1)) begin
            addr_1 <= addr_1 + 1'b1;
            byte_q <= ecpri_byte(cnt[3:0] + 4'd1);
            cnt    <= cnt + 8'd1;
          end else begin
            we_1 <= 1'b0;
            cnt  <= '0;
            if (cur_len != 8'd0) begin
              state  <= COPY_PAYLOAD;
              addr_2 <= cur_addr;
              oe_2   <= 1'b1;
            end else begin
              state        <= DONE;
              tx_pkt_valid <= 1'b1;
              tx_pkt_len   <= ADDR_WIDTH'(FRAME_BASE);
            end
          end
        end
        COPY_PAYLOAD: begin
          cnt <= cnt + 8'd1;
          if (cnt < cur_len) begin
            we_1   <= 1'b1;
            addr_1 <= ADDR_WIDTH'(FRAME_BASE) + ADDR_WIDTH'(cnt);
            src    <= SRC_PAY;
          end else begin
            we_1 <= 1'b0;
          end
          if ((9'(cnt) + 9'd1) < 9'(cur_len)) addr_2 <= addr_2 + 1'b1;
          else                                oe_2   <= 1'b0;
          if (cnt == cur_len) begin
            state        <= DONE;
            tx_pkt_valid <= 1'b1;
            tx_pkt_len   <= ADDR_WIDTH'(FRAME_BASE) + ADDR_WIDTH'(cur_len);
          end
        end
        DONE: begin
          if (tx_ack) begin
            tx_pkt_valid <= 1'b0;
            tx_pkt_len   <= '0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // capture comes last so a pulse on the take edge re-arms the flag
      if (send_read_resp) begin
        rd_pend <= 1'b1;
        rd_len  <= resp_payload_len;
        rd_id   <= resp_id;
        rd_addr <= resp_addr;
      end
      if (send_write_resp) begin
        wr_pend <= 1'b1;
        wr_id   <= resp_id;
        wr_addr <= resp_addr;
      end
    end
  end

  // NOTE: data_1 gets a default first so no path through this block infers a latch.
  always_comb begin
    logic [15:0] ip_len;
    logic [15:0] udp_len;
    ip_len  = 16'd44 + {8'd0, cur_len};
    udp_len = 16'd24 + {8'd0, cur_len};
    data_1  = byte_q;
    case (src)
      SRC_TMPL: data_1 = data_0;
      SRC_PAY:  data_1 = data_2;
      default:  data_1 = byte_q;
    endcase
    if (LEN_FIXUP && src == SRC_TMPL) begin
      if (addr_1 == ADDR_WIDTH'(16)) data_1 = ip_len[15:8];
      if (addr_1 == ADDR_WIDTH'(17)) data_1 = ip_len[7:0];
      if (addr_1 == ADDR_WIDTH'(38)) data_1 = udp_len[15:8];
      if (addr_1 == ADDR_WIDTH'(39)) data_1 = udp_len[7:0];
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_ecpri_tx.sv
// Scoreboard bench for ecpri_tx: RAM models around the DUT, expected frames queued at each pulse
// and compared byte-by-byte (plus length, latency and strobe counts) when tx_pkt_valid rises.
module tb_ecpri_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        send_read_resp = 1'b0, send_write_resp = 1'b0;
  logic [7:0]  resp_payload_len = '0, resp_id = '0;
  logic [15:0] resp_addr = '0;
  logic [15:0] addr_0, addr_1, addr_2, tx_pkt_len;
  logic [7:0]  data_0 = '0, data_2 = '0, data_1;
  logic        oe_0, we_1, oe_2, tx_pkt_valid, busy;
  logic        tx_ack = 1'b0;

  ecpri_tx dut (
    .clk(clk), .reset(reset),
    .send_read_resp(send_read_resp), .send_write_resp(send_write_resp),
    .resp_payload_len(resp_payload_len), .resp_id(resp_id), .resp_addr(resp_addr),
    .addr_0(addr_0), .data_0(data_0), .oe_0(oe_0),
    .addr_1(addr_1), .data_1(data_1), .we_1(we_1),
    .addr_2(addr_2), .data_2(data_2), .oe_2(oe_2),
    .tx_pkt_valid(tx_pkt_valid), .tx_pkt_len(tx_pkt_len), .tx_ack(tx_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_read;
    logic [7:0]  len;
    logic [7:0]  id;
    logic [15:0] addr;
    int          t0;
    int          lat;
  } frame_t;

  frame_t     sb[$];
  logic [7:0] tmpl [0:41];
  logic [7:0] pay  [0:65535];
  logic [7:0] txram[0:65535];
  int         stamp[0:65535];
  int         gen = 1;
  int         cyc = 0;
  int         wr_cnt = 0, oe0_cnt = 0, oe2_cnt = 0, bad_wr = 0;
  int         wr_base = 0, oe0_base = 0, oe2_base = 0;
  int         n_checks = 0, n_fail = 0;

  // RAM models and strobe monitors
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (oe_0) begin
      data_0 <= (addr_0 < 16'd42) ? tmpl[addr_0] : 8'hXX;
      oe0_cnt <= oe0_cnt + 1;
    end
    if (oe_2) begin
      data_2 <= pay[addr_2];
      oe2_cnt <= oe2_cnt + 1;
    end
    if (we_1) begin
      txram[addr_1] <= data_1;
      stamp[addr_1] <= gen;
      wr_cnt <= wr_cnt + 1;
      if (sb.size() == 0 || addr_1 >= 16'd58 + ((sb[0].is_read) ? {8'd0, sb[0].len} : 16'd0))
        bad_wr <= bad_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input frame_t e, input int k);
    logic [15:0] l, v, a;
    logic [7:0]  r;
    l = e.is_read ? {8'd0, e.len} : 16'd0;
    r = 8'h00;
    if (k < 42) begin
      v = 16'(k);
      r = v[7:0];
`ifdef ECPRI_TX_LEN_FIXUP_EN
      v = 16'd44 + l;
      if (k == 16) r = v[15:8];
      if (k == 17) r = v[7:0];
      v = 16'd24 + l;
      if (k == 38) r = v[15:8];
      if (k == 39) r = v[7:0];
`endif
    end else if (k < 58) begin
      v = 16'd12 + l;
      a = e.addr;
      case (k - 42)
        0:  r = 8'h10;
        1:  r = 8'h04;
        2:  r = v[15:8];
        3:  r = v[7:0];
        4:  r = e.id;
        5:  r = e.is_read ? 8'h01 : 8'h11;
        12: r = a[15:8];
        13: r = a[7:0];
        15: r = l[7:0];
        default: r = 8'h00;
      endcase
    end else begin
      a = e.addr + 16'(k - 58);
      r = pay[a];
    end
    return r;
  endfunction

  task automatic send(input bit rd, input bit wr, input logic [7:0] len, input logic [7:0] id,
                      input logic [15:0] addr, input bit replace);
    frame_t e;
    bit     idle_now;
    @(negedge clk);
    idle_now = (sb.size() == 0) && !busy;
    send_read_resp = rd; send_write_resp = wr;
    resp_payload_len = len; resp_id = id; resp_addr = addr;
    if (rd) begin
      e = '{1'b1, len, id, addr, cyc + 1, idle_now ? ((len == 0) ? 60 : 61 + int'(len)) : -1};
      sb.push_back(e);
    end
    if (wr) begin
      e = '{1'b0, len, id, addr, cyc + 1, (idle_now && !rd) ? 60 : -1};
      if (replace && sb.size() > 0) sb[sb.size()-1] = e;
      else                          sb.push_back(e);
    end
    @(negedge clk);
    send_read_resp = 1'b0; send_write_resp = 1'b0;
  endtask

  task automatic wait_frame();
    frame_t e;
    int     n = 0;
    int     l;
    while (tx_pkt_valid !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("frame_valid", 32'(tx_pkt_valid), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      l = e.is_read ? int'(e.len) : 0;
      if (e.lat >= 0) check("latency", 32'(cyc - e.t0), 32'(e.lat));
      check("tx_pkt_len", 32'(tx_pkt_len), 32'(58 + l));
      for (int k = 0; k < 58 + l; k++)
        check($sformatf("txram[%0d]", k),
              (stamp[k] == gen) ? {24'd0, txram[k]} : 32'hDEAD, {24'd0, exp_byte(e, k)});
      check("we_count", 32'(wr_cnt - wr_base), 32'(58 + l));
      check("oe0_count", 32'(oe0_cnt - oe0_base), 32'd42);
      check("oe2_count", 32'(oe2_cnt - oe2_base), 32'(l));
    end
    gen++;
    wr_base = wr_cnt; oe0_base = oe0_cnt; oe2_base = oe2_cnt;
  endtask

  task automatic ack();
    @(negedge clk); tx_ack = 1'b1;
    @(negedge clk); tx_ack = 1'b0;
    check("valid_after_ack", 32'(tx_pkt_valid), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(tx_pkt_valid), 32'd0);
    check({tag, "_we_1"}, 32'(we_1), 32'd0);
    check({tag, "_oe_0"}, 32'(oe_0), 32'd0);
    check({tag, "_oe_2"}, 32'(oe_2), 32'd0);
    check({tag, "_len"}, 32'(tx_pkt_len), 32'd0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < 42; i++) tmpl[i] = 8'(i);
    for (int i = 0; i < 65536; i++) begin
      pay[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      stamp[i] = 0;
    end
    pay[16'h0010] = 8'hAA; pay[16'h0011] = 8'hBB;
    pay[16'h0012] = 8'hCC; pay[16'h0013] = 8'hDD;

    repeat (3) @(negedge clk);
    check_quiet("in_reset");
    check("in_reset_addr_1", 32'(addr_1), 32'd0);
    check("in_reset_data_1", 32'(data_1), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("after_reset");

    // write response, L=0
    send(1'b0, 1'b1, 8'd0, 8'h5A, 16'h1234, 1'b0);
    wait_frame();
    ack();
    check("idle_after_write", 32'(busy), 32'd0);

    // read response L=4, with a stray ack during the build
    send(1'b1, 1'b0, 8'd4, 8'h3C, 16'h0010, 1'b0);
    @(negedge clk); tx_ack = 1'b1;
    @(negedge clk); tx_ack = 1'b0;
    wait_frame();
    ack();

    // simultaneous read+write, read wraps the payload address; repeat write overwrites its slot
    send(1'b1, 1'b1, 8'd3, 8'h77, 16'hFFFE, 1'b0);
    repeat (5) @(negedge clk);
    send(1'b0, 1'b1, 8'd9, 8'h44, 16'hBEEF, 1'b1);
    wait_frame();
    ack();
    wait_frame();
    ack();
    check("idle_after_pair", 32'(busy), 32'd0);

    // read L=0: valid held while ack stays low
    send(1'b1, 1'b0, 8'd0, 8'hE1, 16'h0400, 1'b0);
    wait_frame();
    repeat (10) @(negedge clk);
    check("valid_held", 32'(tx_pkt_valid), 32'd1);
    check("len_held", 32'(tx_pkt_len), 32'd58);
    ack();
    check("idle_after_len0", 32'(busy), 32'd0);

    // reset during payload copy, with a write pending behind it
    send(1'b1, 1'b0, 8'd20, 8'h21, 16'h0100, 1'b0);
    send(1'b0, 1'b1, 8'd0, 8'h22, 16'h0200, 1'b0);
    n = 0;
    while (oe_2 !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("oe2_seen", 32'(oe_2), 32'd1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 check_quiet("mid_reset");
    check("mid_reset_addr_2", 32'(addr_2), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    gen++;
    wr_base = wr_cnt; oe0_base = oe0_cnt; oe2_base = oe2_cnt;
    repeat (80) @(negedge clk);
    check("pending_cleared", 32'(busy), 32'd0);
    check("no_writes_after_reset", 32'(wr_cnt - wr_base), 32'd0);
    send(1'b0, 1'b1, 8'd0, 8'h99, 16'hCAFE, 1'b0);
    wait_frame();
    ack();

    check("bad_writes", 32'(bad_wr), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecpri_tx.md
Name: ecpri_tx

Overview:
- Builds the eCPRI Remote Memory Access response packet in the TX packet RAM.
- Driven by the send_read_resp / send_write_resp pulses from the eCPRI receive path.
- Copies the Eth/IP/UDP header template, appends a 16-byte eCPRI response header and, for read responses, the payload bytes.
- Hands the finished frame to the MAC with a valid/ack handshake.

Parameters:
- DATA_WIDTH, 8, byte lane width (fixed at 8; other values unsupported).
- ADDR_WIDTH, 16, address width of all RAM ports.
- NET_HDR_LEN, 42, Eth(14)+IP(20)+UDP(8) template length in bytes.
- ECPRI_HDR_LEN, 16, eCPRI common (4) + RMA (12) header length.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- send_read_resp  in  1  one-cycle pulse: build read response.
- send_write_resp  in  1  one-cycle pulse: build write response.
- resp_payload_len  in  8  payload byte count for read response; sampled with the pulse.
- resp_id  in  8  RMA ID echoed into the response; sampled with the pulse.
- resp_addr  in  ADDR_WIDTH  memory address echoed, and payload source base for reads; sampled with the pulse.
- addr_0  out  ADDR_WIDTH  header template RAM read address.
- data_0  in  8  header template read data; 1-cycle read latency.
- oe_0  out  1  template read enable.
- addr_1  out  ADDR_WIDTH  TX packet RAM write address.
- data_1  out  8  TX packet RAM write data.
- we_1  out  1  TX packet RAM write enable.
- addr_2  out  ADDR_WIDTH  payload RAM read address.
- data_2  in  8  payload read data; 1-cycle latency.
- oe_2  out  1  payload read enable.
- tx_pkt_valid  out  1  frame complete in TX RAM.
- tx_pkt_len  out  ADDR_WIDTH  frame length in bytes.
- tx_ack  in  1  MAC has consumed the frame.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, pending flags cleared. A reset asserted mid-frame aborts the frame; the TX RAM contents are don't-care.
- Request capture:
  - A pulse, in any state, sets a per-type pending flag and latches len/id/addr into that type's slot.
  - A repeat of the same type while pending overwrites that slot (last wins).
  - Simultaneous read+write pulses latch both; the read is served first.
- IDLE: if read pending -> COPY_HDR with kind=read (clear its flag); else if write pending -> COPY_HDR with kind=write.
- COPY_HDR:
  - Template reads at addr_0 = 0..41 on consecutive cycles, oe_0=1.
  - Each byte is written one cycle later to addr_1 = the same offset (we_1=1).
  - Lasts 43 cycles, then -> WR_ECPRI.
- WR_ECPRI: writes offsets 42..57, one byte per cycle:
  - 0x10, 0x04;
  - payload size (16-bit BE) = 12 + L, where L = len for read, 0 for write;
  - resp_id;
  - 0x01 (read resp) or 0x11 (write resp);
  - 0x00, 0x00 (element ID);
  - 0x00 x4, then resp_addr[15:8], resp_addr[7:0];
  - length BE = 0x00, L.
- WR_ECPRI exit: -> COPY_PAYLOAD if L>0, else DONE.
- COPY_PAYLOAD:
  - addr_2 = resp_addr + i for i=0..L-1, oe_2=1.
  - Writes go to addr_1 = 58+i one cycle later.
  - Lasts L+1 cycles; addr_2 wraps modulo 2^ADDR_WIDTH.
- DONE:
  - tx_pkt_valid=1 and tx_pkt_len=58+L, both held until tx_ack is sampled high.
  - On that edge: valid drops, -> IDLE.
  - tx_ack outside DONE is ignored.
- Latency: tx_pkt_valid rises 60 cycles after the pulse edge for L=0, and 61+L cycles for L>0.
- we_1, oe_0 and oe_2 are low outside their phases; no write is ever issued to TX RAM offset ≥ 58+L.

Optional Feature:
- Macro: ECPRI_TX_LEN_FIXUP_EN.
- Defined:
  - During COPY_HDR, template bytes at offsets 16,17 are replaced by IP total length = 44+L (BE).
  - Offsets 38,39 are replaced by UDP length = 24+L (BE).
  - The IP checksum is copied unchanged.
- Undefined: all 42 bytes are copied verbatim.

Test Plan:
- Template bytes = offset value, write pulse, id=0x5A, addr=0x1234:
  - TX RAM[0..41] = 0..41;
  - [42..57] = 10 04 00 0C 5A 11 00 00 00 00 00 00 12 34 00 00;
  - tx_pkt_len=58, valid at cycle 60.
- Read pulse, len=4, addr=0x0010, payload RAM[0x10..0x13] = AA BB CC DD:
  - [44,45] = 00 10, [47] = 0x01, [57] = 04, [58..61] = AA BB CC DD;
  - len=62, valid at cycle 65.
- Read and write pulses in the same cycle:
  - read frame completes first;
  - after tx_ack the write frame is built without a further pulse.
- Read len=0: no oe_2 activity, tx_pkt_len=58; tx_ack held low 10 cycles keeps valid high, and then ack returns the block to IDLE.
- Reset asserted mid-COPY_PAYLOAD: outputs 0 immediately, pending cleared, and a new write pulse then yields a correct 58-byte frame.
- With ECPRI_TX_LEN_FIXUP_EN, read len=4: [16,17] = 00 30 and [38,39] = 00 1C.
